alu_serial_seq: RTL and testbench

Bit-serial sequencer that executes a WIDTH-bit ALU operation by driving one 1-bit ALU slice per clock, LSB first, with the slice's carry-out registered and fed back as the next bit's carry-in. It replaces a WIDTH-slice ripple array when area matters more than latency. Operands and the op code are captured on a start handshake. The block owns the full-width result, zero, carry-out, overflow and set-less-than handling around the single slice.

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/ALU_1bit.sv | 37 +++
 rtl/alu_serial_seq.sv | 159 +++++++++++++++
 tb/tb_alu_serial_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
//   - ALU op codes ({Ainvert, Binvert, operation[1:0]})
//   - sequencer state encoding
//   - 1-bit slice operation codes
//   - op decoder mapping an op code onto slice controls
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    localparam logic [1:0] SL_AND = 2'b00;
    localparam logic [1:0] SL_OR  = 2'b01;
    localparam logic [1:0] SL_ADD = 2'b10;

    // Slice controls plus the two flags the sequencer needs to finish up.
    typedef struct packed {
        logic       ainv;
        logic       binv;
        logic [1:0] sl;
        logic       arith;   // ADD/SUB/SLT: carry chain is meaningful
        logic       slt;     // result replaced by the sign test at the end
    } op_dec_t;

    // Unsupported codes fall back to a plain AND so slice code 11 is never driven.
    function automatic op_dec_t decode_op(input logic [3:0] op);
        op_dec_t d;
        d = '{ainv: 1'b0, binv: 1'b0, sl: SL_AND, arith: 1'b0, slt: 1'b0};
        case (op)
            OP_AND: d = '{ainv: 1'b0, binv: 1'b0, sl: SL_AND, arith: 1'b0, slt: 1'b0};
            OP_OR:  d = '{ainv: 1'b0, binv: 1'b0, sl: SL_OR,  arith: 1'b0, slt: 1'b0};
            OP_ADD: d = '{ainv: 1'b0, binv: 1'b0, sl: SL_ADD, arith: 1'b1, slt: 1'b0};
            OP_SUB: d = '{ainv: 1'b0, binv: 1'b1, sl: SL_ADD, arith: 1'b1, slt: 1'b0};
            OP_NOR: d = '{ainv: 1'b1, binv: 1'b1, sl: SL_AND, arith: 1'b0, slt: 1'b0};
            OP_SLT: d = '{ainv: 1'b0, binv: 1'b1, sl: SL_ADD, arith: 1'b1, slt: 1'b1};
            default: d = '{ainv: 1'b0, binv: 1'b0, sl: SL_AND, arith: 1'b0, slt: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ALU_1bit.sv
// Combinational 1-bit ALU slice.
//   a, b            operand bits
//   Ainvert/Binvert invert the operand bit before use
//   Cin             carry in
//   operation       00 AND, 01 OR, 10 ADD (11 unused -> 0)
//   sum             selected result bit
//   carry           full-adder carry out of the (inverted) operands
module ALU_1bit
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       Ainvert,
    input  logic       Binvert,
    input  logic       Cin,
    input  logic [1:0] operation,
    output logic       sum,
    output logic       carry
);

    logic aa_s;
    logic bb_s;

    // Operand inversion, carry generation and result select.
    always_comb begin
        aa_s  = a ^ Ainvert;
        bb_s  = b ^ Binvert;
        carry = (aa_s & bb_s) | (aa_s & Cin) | (bb_s & Cin);
        case (operation)
            SL_AND:  sum = aa_s & bb_s;
            SL_OR:   sum = aa_s | bb_s;
            SL_ADD:  sum = aa_s ^ bb_s ^ Cin;
            default: sum = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: runs one ALU_1bit slice per clock, LSB first,
// with the slice carry registered between bits.
//   clk_i, rst_i (sync, active-high)
//   start_i, op_i, a_i, b_i   request and operands, captured in IDLE
//   busy_o                    high in RUN and FIN
//   done_o                    one-cycle pulse in FIN
//   result_o, zero_o, cout_o, overflow_o  final result and flags,
//                             held until the next accepted start
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int              IDXW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);

    state_e           state_r, state_nx_s;
    logic [IDXW-1:0]  idx_r;
    logic [WIDTH-1:0] a_r, b_r, result_r;
    op_dec_t          dec_r;
    logic             carry_r, zero_r, cout_r, ovf_r, busy_r, done_r;

    logic             last_s, cin_s, sum_s, carry_s, ovf_bit_s;
    logic             busy_nx_s, done_nx_s;
    logic [WIDTH-1:0] result_wr_s, result_fin_s;

    ALU_1bit u_slice (
        .a         (a_r[idx_r]),
        .b         (b_r[idx_r]),
        .Ainvert   (dec_r.ainv),
        .Binvert   (dec_r.binv),
        .Cin       (cin_s),
        .operation (dec_r.sl),
        .sum       (sum_s),
        .carry     (carry_s)
    );

    assign last_s = (idx_r == IDX_LAST);

    // State register plus the registered busy/done outputs derived from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= busy_nx_s;
            done_r  <= done_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) state_nx_s = ST_RUN;
                else         state_nx_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_nx_s = ST_FIN;
                else        state_nx_s = ST_RUN;
            end
            ST_FIN:  state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Output/slice-drive logic: carry-in selection and the end-of-run result.
    always_comb begin
        busy_nx_s = (state_nx_s != ST_IDLE);
        done_nx_s = (state_nx_s == ST_FIN);
        // Bit 0 takes Binvert as carry-in so SUB/SLT form the two's complement.
        if (idx_r == '0) cin_s = dec_r.binv;
        else             cin_s = carry_r;
        ovf_bit_s   = cin_s ^ carry_s;
        result_wr_s = result_r;
        result_wr_s[idx_r] = sum_s;
        // SLT: sign of a-b corrected for signed overflow.
        if (dec_r.slt) result_fin_s = {{(WIDTH-1){1'b0}}, sum_s ^ ovf_bit_s};
        else           result_fin_s = result_wr_s;
    end

    // Operand capture, bit index, carry chain, result and flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_r      <= '0;
            b_r      <= '0;
            dec_r    <= '0;
            idx_r    <= '0;
            carry_r  <= 1'b0;
            result_r <= '0;
            zero_r   <= 1'b1;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        a_r      <= a_i;
                        b_r      <= b_i;
                        dec_r    <= decode_op(op_i);
                        idx_r    <= '0;
                        carry_r  <= 1'b0;
                        result_r <= '0;
                        zero_r   <= 1'b0;
                        cout_r   <= 1'b0;
                        ovf_r    <= 1'b0;
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                ST_RUN: begin
                    carry_r <= carry_s;
                    if (last_s) begin
                        result_r <= result_fin_s;
                        zero_r   <= (result_fin_s == '0);
                        cout_r   <= dec_r.arith & ~dec_r.slt & carry_s;
                        ovf_r    <= dec_r.arith & ~dec_r.slt & ovf_bit_s;
                    end else begin
                        result_r <= result_wr_s;
                        idx_r    <= idx_r + IDXW'(1);
                    end
                end
                ST_FIN: begin
                    idx_r   <= '0;
                    carry_r <= 1'b0;
                end
                default: begin
                    idx_r   <= '0;
                    carry_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_r;
    assign done_o     = done_r;
    assign result_o   = result_r;
    assign zero_o     = zero_r;
    assign cout_o     = cout_r;
    assign overflow_o = ovf_r;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq (WIDTH=32): directed corner cases,
// mid-run start/operand changes, mid-run reset and random operations,
// all compared against a plain-arithmetic reference model.
module tb_alu_serial_seq;

    localparam int WIDTH = 32;

    localparam logic [3:0] T_AND = 4'b0000;
    localparam logic [3:0] T_OR  = 4'b0001;
    localparam logic [3:0] T_ADD = 4'b0010;
    localparam logic [3:0] T_SUB = 4'b0110;
    localparam logic [3:0] T_NOR = 4'b1100;
    localparam logic [3:0] T_SLT = 4'b0111;

    logic             clk;
    logic             rst_i;
    logic             start_i;
    logic [3:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             cout_o;
    logic             overflow_o;

    int n_vec;
    int n_miscmp;

    alu_serial_seq #(.WIDTH(WIDTH)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .cout_o     (cout_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: what a full-width ALU would return for this op.
    function automatic void ref_model(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] r,
                                      output logic c, output logic v);
        logic [32:0] w;
        r = 32'd0; c = 1'b0; v = 1'b0;
        case (op)
            T_OR:  r = a | b;
            T_NOR: r = ~(a | b);
            T_ADD: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0]; c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            T_SUB: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            T_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = a & b;
        endcase
    endfunction

    // mode 0: plain op; 1: start pulse + operand change at idx 7; 2: reset at idx 10
    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int mode);
        logic [31:0] er;
        logic        ec, ev;
        int          k, guard, dones;
        bit          seen, aborted;
        guard = 0;
        while (busy_o && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        check("idle_before_start", 32'(busy_o), 32'd0);
        ref_model(op, a, b, er, ec, ev);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk); #1;
        start_i = 1'b0;
        check("busy_after_start", 32'(busy_o), 32'd1);
        check("result_cleared", result_o, 32'd0);
        check("zero_cleared", 32'(zero_o), 32'd0);
        k = 0; seen = 1'b0; aborted = 1'b0;
        while (!seen && !aborted && k < WIDTH + 8) begin
            if (mode == 1 && k == 7) begin
                start_i = 1'b1; a_i = $urandom; b_i = $urandom; op_i = 4'($urandom);
            end
            if (mode == 1 && k == 8) start_i = 1'b0;
            if (mode == 2 && k == 10) rst_i = 1'b1;
            @(posedge clk); #1; k++;
            if (mode == 2 && k == 11) begin
                rst_i = 1'b0;
                aborted = 1'b1;
                check("abort_busy", 32'(busy_o), 32'd0);
                check("abort_result", result_o, 32'd0);
                check("abort_zero", 32'(zero_o), 32'd1);
                check("abort_done", 32'(done_o), 32'd0);
            end else if (done_o) begin
                seen = 1'b1;
            end
        end
        if (aborted) begin
            dones = 0;
            repeat (WIDTH + 6) begin
                @(posedge clk); #1;
                if (done_o) dones++;
            end
            check("no_done_after_abort", 32'(dones), 32'd0);
        end else begin
            check("done_seen", 32'(seen), 32'd1);
            // edges counted from the accepting edge itself
            check("done_latency", 32'(k + 1), 32'(WIDTH + 1));
            check("result", result_o, er);
            check("zero", 32'(zero_o), 32'(er == 32'd0));
            check("cout", 32'(cout_o), 32'(ec));
            check("overflow", 32'(overflow_o), 32'(ev));
            check("busy_in_fin", 32'(busy_o), 32'd1);
            @(posedge clk); #1;
            check("done_single_pulse", 32'(done_o), 32'd0);
            check("busy_after_fin", 32'(busy_o), 32'd0);
            check("result_held", result_o, er);
            if (mode == 1) begin
                dones = 0;
                repeat (4) begin
                    @(posedge clk); #1;
                    if (done_o || busy_o) dones++;
                end
                check("no_queued_op", 32'(dones), 32'd0);
            end
        end
    endtask

    initial begin
        logic [3:0]  rop;
        logic [3:0]  ops [8];
        n_vec = 0; n_miscmp = 0;
        ops[0] = T_AND; ops[1] = T_OR;  ops[2] = T_ADD; ops[3] = T_SUB;
        ops[4] = T_NOR; ops[5] = T_SLT; ops[6] = 4'b0011; ops[7] = 4'b1111;
        clk = 1'b0;
        rst_i = 1'b1; start_i = 1'b1; op_i = T_ADD; a_i = 32'd1; b_i = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        start_i = 1'b0;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_zero", 32'(zero_o), 32'd1);
        check("rst_cout", 32'(cout_o), 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        rst_i = 1'b0;
        @(posedge clk); #1;
        check("idle_after_rst", 32'(busy_o), 32'd0);

        run_op(T_ADD, 32'h7FFFFFFF, 32'h00000001, 0);
        run_op(T_SUB, 32'd5, 32'd5, 0);
        run_op(T_SUB, 32'd0, 32'd1, 0);
        run_op(T_SLT, 32'hFFFFFFFD, 32'd2, 0);
        run_op(T_SLT, 32'h7FFFFFFF, 32'h80000000, 0);
        run_op(T_SLT, 32'h80000000, 32'd1, 0);
        run_op(T_AND, 32'hF0F0F0F0, 32'hFF00FF00, 0);
        run_op(T_OR,  32'hF0F0F0F0, 32'hFF00FF00, 0);
        run_op(T_NOR, 32'd0, 32'd0, 0);
        run_op(T_ADD, 32'hFFFFFFFF, 32'd1, 0);
        run_op(4'b1010, 32'h12345678, 32'h0F0F0F0F, 0);
        run_op(T_ADD, 32'h13572468, 32'h2468ACE0, 1);
        run_op(T_ADD, 32'h00001234, 32'h00005678, 2);
        run_op(T_SUB, 32'h80000000, 32'h00000001, 0);

        for (int i = 0; i < 40; i++) begin
            rop = ops[$urandom_range(0, 7)];
            run_op(rop, $urandom, $urandom, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
